// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared FSM state type and skid sizing
// for the FIFO stream reader.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = 2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready master stream
// carrying FIFO words plus an end-of-burst marker.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order data+last buffer
// between the FIFO read port and the stream output.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [SKID_CW-1:0]    count
);

  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [SKID_DEPTH-1:0] mem_l;
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_d[i] <= '0;
      end
      mem_l  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= push_data;
        mem_l[wr_ptr] <= push_last;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + SKID_CW'(push) - SKID_CW'(pop);
    end
  end

  assign head_data = mem_d[rd_ptr];
  assign head_last = mem_l[rd_ptr];

  // The issue rule upstream guarantees room for every capture.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == SKID_CW'(SKID_DEPTH))
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && count == '0)
  );

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops N words from a registered-read FIFO onto a stream.
// Define FIFO_READER_TIMEOUT_EN to abort bursts that stall on an empty FIFO.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
`ifdef FIFO_READER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_r_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
`ifdef FIFO_READER_TIMEOUT_EN
  output logic                  timeout,
`endif
  fifo_stream_reader_if.master  m
);

  localparam int OW = SKID_CW + 1;

  state_t                state;
  logic [CNT_WIDTH-1:0]  len;
  logic [CNT_WIDTH-1:0]  issued;
  logic [CNT_WIDTH-1:0]  cap_idx;
  logic                  inflight;
  logic                  zero_done;
  logic                  pop_now;
  logic                  stall_hit;
  logic                  flush_end;
  logic [SKID_CW-1:0]    count;
  logic [OW-1:0]         occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  // Occupancy once this cycle's handshake has drained the head.
  assign pop_now = m.m_valid & m.m_ready;
  assign occ     = {1'b0, count} + OW'(inflight) - OW'(pop_now);

  assign fifo_r_en = (state == RUN) & !fifo_empty
                   & (issued < len)
                   & (occ < OW'(SKID_DEPTH))
                   & !stall_hit;

  assign flush_end = (state == FLUSH) & !inflight
                   & ((count == '0)
                   | ((count == SKID_CW'(1)) & pop_now));

  assign done      = zero_done | flush_end;
  assign busy      = (state != IDLE);
  assign m.m_valid = (count != '0);
  assign m.m_data  = head_data;
  assign m.m_last  = head_last & m.m_valid;

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_cnt;
  logic          trunc;

  assign stall_hit = (state == RUN)
                   & (stall_cnt == SW'(TIMEOUT_CYCLES));
  assign timeout   = flush_end & trunc;
`else
  assign stall_hit = 1'b0;
`endif

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_data),
    .push_last (cap_idx == len - CNT_WIDTH'(1)),
    .pop       (pop_now),
    .head_data (head_data),
    .head_last (head_last),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= '0;
      issued    <= '0;
      cap_idx   <= '0;
      inflight  <= 1'b0;
      zero_done <= 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
      stall_cnt <= '0;
      trunc     <= 1'b0;
`endif
    end else begin
      zero_done <= 1'b0;
      inflight  <= fifo_r_en;
      if (fifo_r_en) begin
        issued <= issued + CNT_WIDTH'(1);
      end
      if (inflight) begin
        cap_idx <= cap_idx + CNT_WIDTH'(1);
      end
`ifdef FIFO_READER_TIMEOUT_EN
      if (fifo_r_en) begin
        stall_cnt <= '0;
      end else if (state == RUN && issued < len
                   && fifo_empty && !stall_hit) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            if (burst_len != '0) begin
              len     <= burst_len;
              issued  <= '0;
              cap_idx <= '0;
              state   <= RUN;
`ifdef FIFO_READER_TIMEOUT_EN
              stall_cnt <= '0;
              trunc     <= 1'b0;
`endif
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stall_hit) begin
            state <= FLUSH;
`ifdef FIFO_READER_TIMEOUT_EN
            trunc <= 1'b1;
`endif
          end else if (issued == len) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_end) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with a registered-read
// FIFO model; covers FIFO_READER_TIMEOUT_EN when that macro is set.
module tb_fifo_stream_reader;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       dn;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] burst_len = 8'd0;
  logic       busy;
  logic       done;
  logic       fifo_r_en;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'd0;
`ifdef FIFO_READER_TIMEOUT_EN
  logic       timeout;
`endif

  fifo_stream_reader_if #(.DATA_WIDTH(8)) m_if ();

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .CNT_WIDTH  (8)
`ifdef FIFO_READER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_r_en  (fifo_r_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
`ifdef FIFO_READER_TIMEOUT_EN
    .timeout    (timeout),
`endif
    .m          (m_if)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         outst = 0;
  int         pop_cnt = 0;
  int         hs_cnt = 0;
  int         solo_exp = 0;
  logic       solo_tmo = 1'b0;
  logic       busy_seen = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  int         rdy_mode = 0;
  int         rdy_idx = 0;

  task automatic chk(input string nm, input int got, input int req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic push_word(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic exp_word(input logic [7:0] d, input logic l,
                          input logic dn, input logic t);
    exp_t e;
    e.d = d; e.last = l; e.dn = dn; e.tmo = t;
    exp_q.push_back(e);
  endtask

  // FIFO with registered read port, plus words-owed tracking.
  always @(posedge clk) begin
    if (fifo_r_en && fifo_q.size() != 0) begin
      fifo_data <= fifo_q.pop_front();
      pop_cnt++;
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (!rst_n) outst = 0;
    else outst = outst + int'(fifo_r_en)
               - int'(m_if.m_valid & m_if.m_ready);
  end

  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        m_if.m_ready = (rdy_idx % 3 == 0);
        rdy_idx++;
      end else begin
        m_if.m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic hs;
    exp_t e;
    hs = m_if.m_valid & m_if.m_ready;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_if.m_valid, 1);
        chk("hold_data", m_if.m_data, prev_data);
      end
      if (fifo_r_en) begin
        chk("pop_nonempty", fifo_empty, 0);
        chk("pop_room", int'(outst - int'(hs) < 2), 1);
      end
      if (hs) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h required none", m_if.m_data);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_if.m_data, e.d);
          chk("m_last", m_if.m_last, e.last);
          chk("done_on_hs", done, e.dn);
`ifdef FIFO_READER_TIMEOUT_EN
          chk("timeout_on_hs", timeout, e.tmo);
`endif
        end
      end else if (done) begin
        chk("solo_done", int'(solo_exp > 0), 1);
        if (solo_exp > 0) solo_exp--;
`ifdef FIFO_READER_TIMEOUT_EN
        chk("solo_timeout", timeout, solo_tmo);
`endif
      end
      prev_stall = m_if.m_valid & !m_if.m_ready;
      prev_data  = m_if.m_data;
    end
  end

  task automatic run_burst(input logic [7:0] len, input int exp_cyc,
                           input int poke);
    int cyc = 0;
    @(negedge clk);
    start = 1'b1;
    burst_len = len;
    @(posedge clk);
    #1 start = 1'b0;
    busy_seen = 1'b0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_seen = 1'b1;
      start = (cyc == poke);
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_valid", m_if.m_valid, 0);
    chk("rst_data", m_if.m_data, 0);
    chk("rst_last", m_if.m_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      push_word(8'h10 + 8'(i));
      exp_word(8'h10 + 8'(i), i == 4, i == 4, 1'b0);
    end
    pop_cnt = 0;
    run_burst(8'd5, 7, -1);
    settle();
    chk("pops_full", pop_cnt, 5);

    for (int i = 0; i < 5; i++) begin
      push_word(8'h10 + 8'(i));
      exp_word(8'h10 + 8'(i), i == 4, i == 4, 1'b0);
    end
    pop_cnt = 0;
    rdy_idx = 0;
    rdy_mode = 1;
    run_burst(8'd5, 0, -1);
    rdy_mode = 0;
    settle();
    chk("pops_stall", pop_cnt, 5);

    for (int i = 0; i < 3; i++) begin
      exp_word(8'h50 + 8'(i), i == 2, i == 2, 1'b0);
    end
    pop_cnt = 0;
    fork
      for (int i = 0; i < 3; i++) begin
        repeat (4) @(posedge clk);
        #1 push_word(8'h50 + 8'(i));
      end
    join_none
    run_burst(8'd3, 0, -1);
    settle();
    chk("pops_trickle", pop_cnt, 3);

    pop_cnt = 0;
    solo_exp = 1;
    run_burst(8'd0, 1, -1);
    chk("zero_busy_seen", busy_seen, 0);
    settle();
    chk("zero_pops", pop_cnt, 0);
    chk("zero_done_used", solo_exp, 0);

    for (int i = 0; i < 5; i++) push_word(8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) begin
      exp_word(8'h60 + 8'(i), i == 2, i == 2, 1'b0);
    end
    pop_cnt = 0;
    run_burst(8'd3, 5, 2);
    settle();
    chk("busy_start_pops", pop_cnt, 3);
    chk("fifo_left", fifo_q.size(), 2);
    fifo_q.delete();
    fifo_empty = 1'b1;

    for (int i = 0; i < 5; i++) begin
      push_word(8'h20 + 8'(i));
      exp_word(8'h20 + 8'(i), i == 4, i == 4, 1'b0);
    end
    hs_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    burst_len = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (k < 50 && hs_cnt < 2) begin
      @(posedge clk);
      k++;
    end
    chk("rst_wait", int'(hs_cnt >= 2), 1);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_r_en", fifo_r_en, 0);
    chk("mid_rst_valid", m_if.m_valid, 0);
    chk("mid_rst_data", m_if.m_data, 0);
    chk("mid_rst_last", m_if.m_last, 0);
    exp_q.delete();
    fifo_q.delete();
    fifo_empty = 1'b1;
    push_word(8'h30);
    push_word(8'h31);
    exp_word(8'h30, 1'b0, 1'b0, 1'b0);
    exp_word(8'h31, 1'b1, 1'b1, 1'b0);
    pop_cnt = 0;
    run_burst(8'd2, 4, -1);
    settle();
    chk("post_rst_pops", pop_cnt, 2);

`ifdef FIFO_READER_TIMEOUT_EN
    push_word(8'h40);
    push_word(8'h41);
    exp_word(8'h40, 1'b0, 1'b0, 1'b0);
    exp_word(8'h41, 1'b0, 1'b0, 1'b0);
    solo_exp = 1;
    solo_tmo = 1'b1;
    pop_cnt = 0;
    run_burst(8'd4, 0, -1);
    chk("tmo_pulse", timeout, 1);
    settle();
    chk("tmo_pops", pop_cnt, 2);
    chk("tmo_done_used", solo_exp, 0);
    solo_tmo = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
